// File: rtl/display_scroll_sequencer.sv
// display_scroll_sequencer: nibble message buffer and scroll scheduler
// feeding the four data inputs of the 4-digit 7-segment display controller.
//
// Ports:
//   i_Clk, i_Rst           clock (rising edge), async active-low reset
//   i_Wr_Valid/i_Wr_Data   append one nibble; o_Wr_Ready accepts it
//   i_Start/i_Stop/i_Clear run control (Clear > Stop > tick > Start > write)
//   o_Datos1..o_Datos4     digit nibbles, o_Datos1 is the leftmost digit
//   o_Busy                 high while scrolling
//   o_Wrap                 one-cycle pulse when the window returns to index 0
//   o_Count                number of stored nibbles
//
// Build option: define SCROLL_ONESHOT_EN to stop after one full pass
// (the wrap advance returns the block to idle).
module display_scroll_sequencer #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter logic [3:0]  BLANK    = 4'hF
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_Wr_Valid,
    input  logic [3:0]              i_Wr_Data,
    output logic                    o_Wr_Ready,
    input  logic                    i_Start,
    input  logic                    i_Stop,
    input  logic                    i_Clear,
    output logic [3:0]              o_Datos1,
    output logic [3:0]              o_Datos2,
    output logic [3:0]              o_Datos3,
    output logic [3:0]              o_Datos4,
    output logic                    o_Busy,
    output logic                    o_Wrap,
    output logic [$clog2(DEPTH):0]  o_Count
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;
    localparam int unsigned PW = $clog2(TICK_DIV);

    localparam logic [PW-1:0] P_LAST  = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_MIN   = CW'(5);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   w_q, w_d;
    logic [PW-1:0]   p_q, p_d;
    logic [3:0]      buf_q   [DEPTH];
    logic [3:0]      buf_d   [DEPTH];
    logic [3:0]      datos_q [4];
    logic [3:0]      datos_d [4];
    logic            busy_q, busy_d;
    logic            wrap_q, wrap_d;
    logic            wr_fire;
    logic            tick;

    // Next-state: control, window, prescaler and buffer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        p_d     = p_q;
        buf_d   = buf_q;
        wrap_d  = 1'b0;
        wr_fire = (state_q == S_IDLE) && i_Wr_Valid && (cnt_q < C_DEPTH);
        tick    = (state_q == S_RUN) && (p_q == P_LAST);

        if (i_Clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            w_d     = '0;
            p_d     = '0;
        end else if (state_q == S_RUN) begin
            if (i_Stop) begin
                state_d = S_IDLE;
                w_d     = '0;
                p_d     = '0;
            end else if (tick) begin
                p_d = '0;
                if ({1'b0, w_q} == cnt_q - CW'(1)) begin
                    w_d    = '0;
                    wrap_d = 1'b1;
`ifdef SCROLL_ONESHOT_EN
                    state_d = S_IDLE;
`endif
                end else begin
                    w_d = w_q + IW'(1);
                end
            end else begin
                p_d = p_q + PW'(1);
            end
        end else begin
            if (wr_fire) begin
                buf_d[cnt_q[IW-1:0]] = i_Wr_Data;
                cnt_d                = cnt_q + CW'(1);
            end
            // Start sees the count including a same-cycle write.
            if (i_Start && !i_Stop && (cnt_d >= C_MIN)) begin
                state_d = S_RUN;
                w_d     = '0;
                p_d     = '0;
            end
        end

        busy_d = (state_d == S_RUN);
    end

    // Digit window from the next-state values so the outputs
    // change on the same edge as the event that caused them.
    always_comb begin : digit_map
        logic [CW-1:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) begin
            s = {1'b0, w_d} + CW'(k);
            if (s >= cnt_d) begin
                s = s - cnt_d;
            end
            datos_d[k] = (CW'(k) < cnt_d) ? buf_d[s[IW-1:0]] : BLANK;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_q[i] <= '0;
            end
            for (int k = 0; k < 4; k++) begin
                datos_q[k] <= BLANK;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
            buf_q   <= buf_d;
            datos_q <= datos_d;
        end
    end

    assign o_Wr_Ready = i_Rst && (state_q == S_IDLE) && (cnt_q < C_DEPTH);
    assign o_Datos1   = datos_q[0];
    assign o_Datos2   = datos_q[1];
    assign o_Datos3   = datos_q[2];
    assign o_Datos4   = datos_q[3];
    assign o_Busy     = busy_q;
    assign o_Wrap     = wrap_q;
    assign o_Count    = cnt_q;

endmodule

// File: tb/tb_display_scroll_sequencer.sv
// Self-checking bench for display_scroll_sequencer (DEPTH=8, TICK_DIV=4):
// directed scenarios plus randomized traffic against a queue-based model.
module tb_display_scroll_sequencer;

    localparam int         DEPTH    = 8;
    localparam int         TICK_DIV = 4;
    localparam logic [3:0] BLANK    = 4'hF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [3:0] wr_data = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       ready;
    logic [3:0] d1, d2, d3, d4;
    logic       busy;
    logic       wrap;
    logic [3:0] count;

    display_scroll_sequencer #(
        .DEPTH    (DEPTH),
        .TICK_DIV (TICK_DIV),
        .BLANK    (BLANK)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst_n),
        .i_Wr_Valid (wr_valid),
        .i_Wr_Data  (wr_data),
        .o_Wr_Ready (ready),
        .i_Start    (start),
        .i_Stop     (stop),
        .i_Clear    (clear),
        .o_Datos1   (d1),
        .o_Datos2   (d2),
        .o_Datos3   (d3),
        .o_Datos4   (d4),
        .o_Busy     (busy),
        .o_Wrap     (wrap),
        .o_Count    (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // Model: message queue, running flag, window start, edges since
    // the last start/advance, and the wrap pulse of the last edge.
    logic [3:0] m_msg[$];
    bit         m_run;
    int         m_w;
    int         m_ph;
    bit         m_wrap;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_msg.delete();
        m_run  = 1'b0;
        m_w    = 0;
        m_ph   = 0;
        m_wrap = 1'b0;
    endtask

    task automatic model_step();
        m_wrap = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else if (clear) begin
            m_msg.delete();
            m_run = 1'b0;
            m_w   = 0;
            m_ph  = 0;
        end else if (m_run) begin
            if (stop) begin
                m_run = 1'b0;
                m_w   = 0;
                m_ph  = 0;
            end else begin
                m_ph++;
                if (m_ph == TICK_DIV) begin
                    m_ph = 0;
                    m_w  = (m_w + 1) % m_msg.size();
                    if (m_w == 0) begin
                        m_wrap = 1'b1;
`ifdef SCROLL_ONESHOT_EN
                        m_run = 1'b0;
`endif
                    end
                end
            end
        end else begin
            if (wr_valid && m_msg.size() < DEPTH) m_msg.push_back(wr_data);
            if (start && m_msg.size() >= 5) begin
                m_run = 1'b1;
                m_w   = 0;
                m_ph  = 0;
            end
        end
    endtask

    function automatic logic [3:0] exp_digit(input int k);
        int n;
        n = m_msg.size();
        if (!m_run && k >= n) return BLANK;
        return m_msg[(m_w + k) % n];
    endfunction

    function automatic logic exp_ready();
        return rst_n && !m_run && (m_msg.size() < DEPTH);
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("datos1", d1, exp_digit(0));
            chk("datos2", d2, exp_digit(1));
            chk("datos3", d3, exp_digit(2));
            chk("datos4", d4, exp_digit(3));
            chk("busy", busy, m_run);
            chk("wrap", wrap, m_wrap);
            chk("count", count, m_msg.size());
            chk("ready", ready, exp_ready());
        end
    end

    task automatic cycle(input bit v, input logic [3:0] d, input bit st,
                         input bit sp, input bit cl);
        wr_valid = v;
        wr_data  = d;
        start    = st;
        stop     = sp;
        clear    = cl;
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_digits(input string name, input logic [15:0] exp);
        chk(name, {d1, d2, d3, d4}, exp);
    endtask

    initial begin
        bit v, st, sp, cl;
        model_reset();
        cmp_en = 1'b1;

        // 1: reset, then release
        repeat (3) cycle(0, 0, 0, 0, 0);
        chk_digits("rst_digits", 16'hFFFF);
        chk("rst_ready", ready, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", ready, 1'b1);
        chk("rel_count", count, 4'd0);
        chk("rel_busy", busy, 1'b0);

        // 2: short message, Start ignored
        cycle(1, 4'h1, 0, 0, 0);
        chk("first_write", d1, 4'h1);
        cycle(1, 4'h2, 0, 0, 0);
        cycle(1, 4'h3, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        chk_digits("short_digits", 16'h123F);
        chk("short_count", count, 4'd3);
        chk("short_busy", busy, 1'b0);

        // 3: six-nibble scroll
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) cycle(1, 4'(i), 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        chk("run_busy", busy, 1'b1);
        chk_digits("run_w0", 16'h0123);
        repeat (3) cycle(0, 0, 0, 0, 0);
        chk_digits("run_hold", 16'h0123);
        cycle(0, 0, 0, 0, 0);
        chk_digits("run_w1", 16'h1234);
        repeat (16) cycle(0, 0, 0, 0, 0);
        chk_digits("run_w5", 16'h5012);
        chk("run_w5_wrap", wrap, 1'b0);
        repeat (4) cycle(0, 0, 0, 0, 0);
        chk_digits("run_wrap_digits", 16'h0123);
        chk("run_wrap", wrap, 1'b1);
`ifdef SCROLL_ONESHOT_EN
        chk("oneshot_busy", busy, 1'b0);
`else
        chk("loop_busy", busy, 1'b1);
`endif
        cycle(0, 0, 0, 0, 0);
        chk("wrap_one_cycle", wrap, 1'b0);
`ifdef SCROLL_ONESHOT_EN
        repeat (8) cycle(0, 0, 0, 0, 0);
        chk_digits("oneshot_held", 16'h0123);
        cycle(0, 0, 1, 0, 0);
`endif

        // 5: Clear and Stop together while running
        chk("pre_clear_busy", busy, 1'b1);
        cycle(0, 0, 0, 1, 1);
        chk("clr_busy", busy, 1'b0);
        chk("clr_count", count, 4'd0);
        chk_digits("clr_digits", 16'hFFFF);
        chk("clr_ready", ready, 1'b1);

        // 4: nine back-to-back writes into an 8-deep buffer
        for (int i = 0; i < 9; i++) begin
            chk("fill_ready", ready, (i < 8));
            cycle(1, 4'(i + 3), 0, 0, 0);
        end
        cycle(0, 0, 0, 0, 0);
        chk("full_count", count, 4'd8);
        chk("full_ready", ready, 1'b0);
        chk_digits("full_digits", 16'h3456);

        // async reset while running
        cycle(0, 0, 1, 0, 0);
        repeat (6) cycle(0, 0, 0, 0, 0);
        chk_digits("mid_run", 16'h4567);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_digits("arst_digits", 16'hFFFF);
        chk("arst_busy", busy, 1'b0);
        chk("arst_count", count, 4'd0);
        chk("arst_ready", ready, 1'b0);
        repeat (2) cycle(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cycle(0, 0, 0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cl = ($urandom_range(0, 99) < 1);
            sp = ($urandom_range(0, 99) < 3);
            st = !sp && ($urandom_range(0, 99) < 10);
            v  = !sp && ($urandom_range(0, 1) == 1);
            cycle(v, 4'($urandom), st, sp, cl);
        end

        cycle(0, 0, 0, 0, 0);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
